// File: rtl/dual_count_arbiter.sv
// Round-robin arbiter sharing one dual-channel event counter between two burst requesters.
// Channel 1 bursts are scaled by the counter's prescale so the requester sees visible increments.
module dual_count_arbiter #(
  parameter int LEN_W      = 16,
  parameter int DIV1_SHIFT = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [LEN_W-1:0] Len0,
  output logic             Ack0,
  output logic             Done0,
  input  logic             Req1,
  input  logic [LEN_W-1:0] Len1,
  output logic             Ack1,
  output logic             Done1,
  input  logic             Clr,
  output logic             ClrAck,
  output logic             Cnt_En,
  output logic             Cnt_Slt,
  output logic             Cnt_Reset,
  output logic             Busy
);

  localparam int REM_W = LEN_W + DIV1_SHIFT;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           r_state;
  logic [REM_W-1:0] r_remaining;
  logic             r_gnt;
  logic             r_rrLast;
  logic             r_ack;

  logic             w_anyReq;
  logic             w_gntNext;
  logic [REM_W-1:0] w_load;

  // On a tie the channel that did not win last time is granted.
  always_comb begin
    w_anyReq  = Req0 | Req1;
    w_gntNext = (Req0 && Req1) ? ~r_rrLast : Req1;
    w_load    = w_gntNext ? (REM_W'(Len1) << DIV1_SHIFT) : REM_W'(Len0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_gnt       <= 1'b0;
      r_rrLast    <= 1'b1;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Clr) begin
            r_state <= CLEAR;
          end else if (w_anyReq) begin
            r_gnt       <= w_gntNext;
            r_rrLast    <= w_gntNext;
            r_remaining <= w_load;
            r_ack       <= 1'b1;
            r_state     <= (w_load != '0) ? RUN : DONE;
          end
        end
        CLEAR: r_state <= IDLE;
        RUN: begin
          r_remaining <= r_remaining - REM_W'(1);
          if (r_remaining == REM_W'(1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; Cnt_Slt keeps the last grant while idle.
  assign Ack0      = r_ack & ~r_gnt;
  assign Ack1      = r_ack &  r_gnt;
  assign Done0     = (r_state == DONE) & ~r_gnt;
  assign Done1     = (r_state == DONE) &  r_gnt;
  assign ClrAck    = (r_state == CLEAR);
  assign Cnt_Reset = (r_state == CLEAR);
  assign Cnt_En    = (r_state == RUN);
  assign Cnt_Slt   = r_gnt;
  assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dual_count_arbiter.sv
// Directed self-checking bench for dual_count_arbiter with a behavioural model of the shared counter.
module tb_dual_count_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0, Clr = 1'b0;
  logic [15:0] Len0 = '0, Len1 = '0;
  logic        Ack0, Done0, Ack1, Done1, ClrAck, Cnt_En, Cnt_Slt, Cnt_Reset, Busy;

  int nAsserts = 0;
  int nFail = 0;

  int cnt0 = 0, raw1 = 0;
  int ack0N = 0, ack1N = 0, done0N = 0, done1N = 0, en0N = 0, en1N = 0;
  int bCnt0, bRaw1, bAck0, bAck1, bDone0, bDone1, bEn0, bEn1;

  dual_count_arbiter #(.LEN_W(16), .DIV1_SHIFT(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Len0(Len0), .Ack0(Ack0), .Done0(Done0),
    .Req1(Req1), .Len1(Len1), .Ack1(Ack1), .Done1(Done1),
    .Clr(Clr), .ClrAck(ClrAck),
    .Cnt_En(Cnt_En), .Cnt_Slt(Cnt_Slt), .Cnt_Reset(Cnt_Reset), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Counter model plus pulse statistics, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Cnt_Reset) begin
      cnt0 <= 0;
      raw1 <= 0;
    end else if (Cnt_En) begin
      if (Cnt_Slt) raw1 <= raw1 + 1;
      else         cnt0 <= cnt0 + 1;
    end
    if (Cnt_En && !Cnt_Slt) en0N <= en0N + 1;
    if (Cnt_En &&  Cnt_Slt) en1N <= en1N + 1;
    if (Ack0)  ack0N  <= ack0N + 1;
    if (Ack1)  ack1N  <= ack1N + 1;
    if (Done0) done0N <= done0N + 1;
    if (Done1) done1N <= done1N + 1;
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    bCnt0 = cnt0; bRaw1 = raw1; bAck0 = ack0N; bAck1 = ack1N;
    bDone0 = done0N; bDone1 = done1N; bEn0 = en0N; bEn1 = en1N;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40 && Busy; i++) step();
    checkOutput("idle_timeout", Busy, 0);
  endtask

  initial begin
    step();
    step();
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_en", Cnt_En, 0);
    checkOutput("rst_slt", Cnt_Slt, 0);
    checkOutput("rst_ack", Ack0 | Ack1, 0);
    checkOutput("rst_done", Done0 | Done1, 0);
    checkOutput("rst_clr", Cnt_Reset | ClrAck, 0);

    $display("[TB] ch0 burst of 3");
    Reset = 1'b0; Req0 = 1'b1; Len0 = 16'd3;
    snapshot();
    step();
    checkOutput("t1_ack0", Ack0, 1);
    Req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t1_en", Cnt_En, 1);
      checkOutput("t1_slt", Cnt_Slt, 0);
      step();
    end
    checkOutput("t1_done0", Done0, 1);
    checkOutput("t1_done_en", Cnt_En, 0);
    checkOutput("t1_done_busy", Busy, 1);
    checkOutput("t1_out0", cnt0, 3);
    step();
    checkOutput("t1_busy_end", Busy, 0);
    checkOutput("t1_done_once", done0N - bDone0, 1);

    $display("[TB] ch1 burst of 2");
    snapshot();
    Req1 = 1'b1; Len1 = 16'd2;
    for (int i = 0; i < 10 && !Ack1; i++) step();
    checkOutput("t2_ack1", Ack1, 1);
    Req1 = 1'b0;
    waitIdle();
    checkOutput("t2_en1", en1N - bEn1, 8);
    checkOutput("t2_en0", en0N - bEn0, 0);
    checkOutput("t2_out1", raw1 >> 2, 2);
    checkOutput("t2_done1", done1N - bDone1, 1);
    checkOutput("t2_ch0_quiet", (ack0N - bAck0) + (done0N - bDone0), 0);

    $display("[TB] round-robin contention");
    Reset = 1'b1; Req0 = 1'b1; Req1 = 1'b1; Len0 = 16'd1; Len1 = 16'd1;
    step();
    Reset = 1'b0;
    snapshot();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20 && !(Ack0 || Ack1); i++) step();
      checkOutput("t3_ack", Ack0 | Ack1, 1);
      checkOutput("t3_grant", Ack1, k % 2);
      if (Ack0) Req0 = 1'b0;
      else      Req1 = 1'b0;
      step();
      if (k < 3) begin
        Req0 = 1'b1;
        Req1 = 1'b1;
      end
    end
    waitIdle();
    checkOutput("t3_out0", cnt0 - bCnt0, 2);
    checkOutput("t3_out1", (raw1 - bRaw1) >> 2, 2);

    $display("[TB] zero-length ch0 request");
    snapshot();
    Req0 = 1'b1; Len0 = 16'd0;
    for (int i = 0; i < 10 && !Ack0; i++) step();
    checkOutput("t4_ack0", Ack0, 1);
    Req0 = 1'b0;
    step();
    step();
    checkOutput("t4_busy", Busy, 0);
    checkOutput("t4_acks", ack0N - bAck0, 1);
    checkOutput("t4_dones", done0N - bDone0, 1);
    checkOutput("t4_no_en", (en0N - bEn0) + (en1N - bEn1), 0);
    checkOutput("t4_out0", cnt0, bCnt0);

    $display("[TB] clear during a ch0 burst of 5");
    snapshot();
    Req0 = 1'b1; Len0 = 16'd5;
    for (int i = 0; i < 10 && !Ack0; i++) step();
    checkOutput("t5_ack0", Ack0, 1);
    Req0 = 1'b0;
    step();
    Clr = 1'b1; Req1 = 1'b1; Len1 = 16'd1;
    for (int i = 0; i < 20 && !Done0; i++) step();
    checkOutput("t5_done0", Done0, 1);
    checkOutput("t5_out0", cnt0 - bCnt0, 5);
    checkOutput("t5_no_early_clr", Cnt_Reset, 0);
    step();
    checkOutput("t5_idle", Busy, 0);
    step();
    checkOutput("t5_cnt_reset", Cnt_Reset, 1);
    checkOutput("t5_clrack", ClrAck, 1);
    checkOutput("t5_no_ack1", Ack1, 0);
    Clr = 1'b0;
    step();
    checkOutput("t5_clr_pulse", Cnt_Reset | ClrAck, 0);
    checkOutput("t5_cleared", cnt0 + raw1, 0);
    step();
    checkOutput("t5_ack1_after", Ack1, 1);
    Req1 = 1'b0;
    waitIdle();

    $display("[TB] reset mid-burst");
    snapshot();
    Req0 = 1'b1; Len0 = 16'd6;
    for (int i = 0; i < 10 && !Ack0; i++) step();
    checkOutput("t6_ack0", Ack0, 1);
    Req0 = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checkOutput("t6_en", Cnt_En, 0);
    checkOutput("t6_busy", Busy, 0);
    checkOutput("t6_enables", en0N - bEn0, 2);
    for (int i = 0; i < 6; i++) step();
    checkOutput("t6_no_done", done0N - bDone0, 0);
    Req0 = 1'b1; Req1 = 1'b1; Len0 = 16'd1; Len1 = 16'd1;
    for (int i = 0; i < 10 && !(Ack0 || Ack1); i++) step();
    checkOutput("t6_tie_ack0", Ack0, 1);
    checkOutput("t6_tie_ack1", Ack1, 0);
    Req0 = 1'b0;
    step();
    Req1 = 1'b0;
    for (int i = 0; i < 20 && !Ack1; i++) step();
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
